// File: rtl/glove_window_buffer.sv
// glove_window_buffer: serial-sample to sliding-window frame buffer.
// Samples arrive one channel per beat. Each completed frame shifts into a
// DEPTH-frame window. The window is offered to the core through a
// valid/ready handshake once warm-up is done, and every HOP frames after that.
module glove_window_buffer #(
    parameter int CH    = 8,
    parameter int DEPTH = 5,
    parameter int W     = 16,
    parameter int HOP   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [W-1:0]                 i_sample,
    input  logic                         i_flush,
    output logic [DEPTH*CH*W-1:0]        o_window,
    output logic                         o_window_valid,
    input  logic                         i_core_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_fill,
    output logic [15:0]                  o_frame_count
);
    localparam int CW      = (CH > 1) ? $clog2(CH) : 1;
    localparam int FW      = $clog2(DEPTH + 1);
    localparam int HW      = (HOP > 1) ? $clog2(HOP + 1) : 1;
    localparam int FRAME_W = CH * W;
    localparam int WIN_W   = DEPTH * FRAME_W;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      ch_idx_q, ch_idx_d;
    logic [W-1:0]       stage_q [CH];
    logic [W-1:0]       stage_d [CH];
    logic [WIN_W-1:0]   window_q, window_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [HW-1:0]      hop_cnt_q, hop_cnt_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic               accept;
    logic               commit;
    logic [FW-1:0]      fill_inc;
    logic [HW-1:0]      hop_inc;
    logic [FRAME_W-1:0] new_frame;
    logic [WIN_W-1:0]   window_shift;

    // A flushed beat is discarded, so it is never treated as accepted.
    assign accept   = i_valid && (state_q != S_PEND) && !i_flush;
    assign commit   = accept && (ch_idx_q == CW'(CH - 1));
    assign fill_inc = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
    assign hop_inc  = hop_cnt_q + HW'(1);

    // The incoming frame takes the staged channels plus the live last-channel
    // sample. The window then drops frame 0 and moves the rest down one slot.
    genvar gi;
    generate
        for (gi = 0; gi < CH - 1; gi++) begin : g_new_frame
            assign new_frame[gi*W +: W] = stage_q[gi];
        end
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_shift
            assign window_shift[gi*FRAME_W +: FRAME_W] = window_q[(gi+1)*FRAME_W +: FRAME_W];
        end
    endgenerate
    assign new_frame[(CH-1)*W +: W]                 = i_sample;
    assign window_shift[(DEPTH-1)*FRAME_W +: FRAME_W] = new_frame;

    // Datapath next state: staging register, channel index, window, frame counter.
    always_comb begin
        stage_d       = stage_q;
        ch_idx_d      = ch_idx_q;
        window_d      = window_q;
        frame_count_d = frame_count_q;
        if (accept) begin
            stage_d[ch_idx_q] = i_sample;
            ch_idx_d          = commit ? '0 : ch_idx_q + CW'(1);
        end
        if (commit) begin
            window_d      = window_shift;
            frame_count_d = frame_count_q + 16'd1;
        end
        if (i_flush) begin
            stage_d  = '{default: '0};
            ch_idx_d = '0;
            window_d = '0;
        end
    end

    // Offer control next state: warm-up fill, hop spacing, pending handshake.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        hop_cnt_d = hop_cnt_q;
        if (commit) begin
            fill_d = fill_inc;
        end
        case (state_q)
            S_FILL: begin
                if (commit && (fill_inc == FW'(DEPTH))) begin
                    state_d   = S_PEND;
                    hop_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (commit) begin
                    if (hop_inc == HW'(HOP)) begin
                        state_d   = S_PEND;
                        hop_cnt_d = '0;
                    end else begin
                        hop_cnt_d = hop_inc;
                    end
                end
            end
            S_PEND: begin
                if (i_core_ready) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_FILL;
        endcase
        if (i_flush) begin
            state_d   = S_FILL;
            fill_d    = '0;
            hop_cnt_d = '0;
        end
    end

    // All state registers. Reset clears everything, including the frame counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_FILL;
            ch_idx_q      <= '0;
            stage_q       <= '{default: '0};
            window_q      <= '0;
            fill_q        <= '0;
            hop_cnt_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ch_idx_q      <= ch_idx_d;
            stage_q       <= stage_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            hop_cnt_q     <= hop_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign o_ready        = (state_q != S_PEND);
    assign o_window_valid = (state_q == S_PEND);
    assign o_window       = window_q;
    assign o_fill         = fill_q;
    assign o_frame_count  = frame_count_q;

endmodule

// File: tb/tb_glove_window_buffer.sv
// Testbench for glove_window_buffer. A queue-based sliding-window model
// predicts each offered window into a scoreboard. A separate monitor
// compares the DUT against it every cycle and pops on each handshake.
// A second instance (CH=2, DEPTH=4, HOP=3) checks hop spacing.
module tb_glove_window_buffer;
    localparam int CH       = 8;
    localparam int DEPTH    = 5;
    localparam int W        = 16;
    localparam int HOP      = 1;
    localparam int FRAME_W  = CH * W;
    localparam int WIN_W    = DEPTH * FRAME_W;
    localparam int CH2      = 2;
    localparam int DEPTH2   = 4;
    localparam int HOP2     = 3;
    localparam int WIN2_W   = DEPTH2 * CH2 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT 1 (default parameters) ----------------
    logic               rst_n, valid, flush, core_ready;
    logic [W-1:0]       sample;
    logic               ready, win_valid;
    logic [WIN_W-1:0]   window;
    logic [2:0]         fill;
    logic [15:0]        fcount;

    glove_window_buffer #(.CH(CH), .DEPTH(DEPTH), .W(W), .HOP(HOP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_sample(sample), .i_flush(flush), .o_window(window),
        .o_window_valid(win_valid), .i_core_ready(core_ready),
        .o_fill(fill), .o_frame_count(fcount)
    );

    // ---------------- DUT 2 (hop spacing) ----------------
    logic               valid2, core_ready2, flush2;
    logic [W-1:0]       sample2;
    logic               ready2, win_valid2;
    logic [WIN2_W-1:0]  window2;
    logic [2:0]         fill2;
    logic [15:0]        fcount2;

    glove_window_buffer #(.CH(CH2), .DEPTH(DEPTH2), .W(W), .HOP(HOP2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(ready2),
        .i_sample(sample2), .i_flush(flush2), .o_window(window2),
        .o_window_valid(win_valid2), .i_core_ready(core_ready2),
        .o_fill(fill2), .o_frame_count(fcount2)
    );

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for DUT 1 ----------------
    logic [FRAME_W-1:0] m_hist[$];   // last DEPTH committed frames, oldest first
    logic [FRAME_W-1:0] m_stage;
    int                 m_ch;
    int                 m_n;         // commits since reset/flush
    int                 m_fc;        // total commits, wraps at 2^16
    logic [WIN_W-1:0]   sb[$];       // expected offers, oldest first
    int                 offers;
    int                 last_wait;
    bit                 mon_en = 1'b0;

    function automatic logic [WIN_W-1:0] model_window();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int f = 0; f < DEPTH; f++) w[f*FRAME_W +: FRAME_W] = m_hist[f];
        return w;
    endfunction

    function automatic void model_clear();
        m_hist.delete();
        for (int f = 0; f < DEPTH; f++) m_hist.push_back('0);
        m_stage = '0;
        m_ch    = 0;
        m_n     = 0;
        sb.delete();
    endfunction

    function automatic void model_accept(input logic [W-1:0] v);
        m_stage[m_ch*W +: W] = v;
        m_ch++;
        if (m_ch == CH) begin
            m_ch = 0;
            void'(m_hist.pop_front());
            m_hist.push_back(m_stage);
            m_n++;
            m_fc = (m_fc + 1) % 65536;
            if (m_n == DEPTH || (m_n > DEPTH && ((m_n - DEPTH) % HOP) == 0))
                sb.push_back(model_window());
        end
    endfunction

    // Present one beat to DUT 1 and hold it until accepted. Call at a negedge.
    task automatic send(input logic [W-1:0] v, input bit rand_core);
        logic rdy;
        int   waited = 0;
        bit   done   = 1'b0;
        valid  = 1'b1;
        sample = v;
        while (!done) begin
            if (rand_core) core_ready = ($urandom_range(0, 2) != 0);
            rdy = ready;
            @(posedge clk);
            @(negedge clk);
            waited++;
            if (rdy) begin
                model_accept(v);
                done = 1'b1;
            end else if (waited > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=%0d cycles required<=200", waited);
                done = 1'b1;
            end
        end
        last_wait = waited;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int f);
        for (int c = 0; c < CH; c++) send(W'(16*f + c), 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_fc = 0;
        model_clear();
        rst_n = 1'b1;
    endtask

    // Monitor for DUT 1: compares every cycle, pops the scoreboard on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("offer_valid", win_valid, sb.size() > 0);
                check("ready", ready, sb.size() == 0);
                check("window", window, model_window());
                check("fill", fill, (m_n < DEPTH) ? m_n : DEPTH);
                check("frame_count", fcount, m_fc);
                if (win_valid && sb.size() > 0) begin
                    check("offer_window", window, sb[0]);
                    if (core_ready && rst_n && !flush) begin
                        void'(sb.pop_front());
                        offers++;
                        $display("offer %0d taken frame_count=%0d", offers, fcount);
                    end
                end
            end
        end
    end

    // ---------------- DUT 2 monitor and driver ----------------
    logic [15:0] got2[$];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && win_valid2 && core_ready2) begin
                logic [WIN2_W-1:0] exp2;
                int f;
                got2.push_back(fcount2);
                for (int k = 0; k < DEPTH2 * CH2; k++) begin
                    f = int'(fcount2) - DEPTH2 + k / CH2;
                    exp2[k*W +: W] = W'(16*f + (k % CH2));
                end
                check("hop_window", window2, exp2);
                $display("hop offer taken frame_count=%0d", fcount2);
            end
        end
    end

    task automatic send2(input logic [W-1:0] v);
        logic rdy;
        int   waited = 0;
        bit   done   = 1'b0;
        valid2  = 1'b1;
        sample2 = v;
        while (!done) begin
            rdy = ready2;
            @(posedge clk);
            @(negedge clk);
            waited++;
            if (rdy) done = 1'b1;
            else if (waited > 200) begin
                checks++;
                failures++;
                $display("FAIL send2_timeout actual=%0d cycles required<=200", waited);
                done = 1'b1;
            end
        end
        valid2 = 1'b0;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_hops[3];
        logic [WIN_W-1:0] snap;
        int base;
        exp_hops = '{4, 7, 10};
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; core_ready = 1'b1; sample = '0;
        valid2 = 1'b0; flush2 = 1'b0; core_ready2 = 1'b1; sample2 = '0;
        offers = 0; last_wait = 0; m_fc = 0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset values
        check("rst_ready", ready, 1);
        check("rst_valid", win_valid, 0);
        check("rst_window", window, 0);
        check("rst_fill", fill, 0);
        check("rst_frame_count", fcount, 0);

        // Hop spacing on the second instance: 12 frames, offers after 4, 7, 10
        for (int f = 0; f < 12; f++)
            for (int c = 0; c < CH2; c++) send2(W'(16*f + c));
        repeat (3) @(negedge clk);
        check("hop_offer_count", got2.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got2.size()) check("hop_offer_frame", got2[i], exp_hops[i]);

        // Warm-up: 40 beats, a single offer after the last
        for (int f = 0; f < DEPTH; f++) send_frame(f);
        idle(1);
        check("warmup_offers", offers, 1);

        // Sliding at HOP=1: three more frames, three more offers
        for (int f = DEPTH; f < DEPTH + 3; f++) send_frame(f);
        idle(1);
        check("slide_offers", offers, 4);
        check("slide_frame_count", fcount, 8);

        // Back-pressure: offer stalls 20 cycles with a held beat
        core_ready = 1'b0;
        send_frame(8);
        snap   = window;
        valid  = 1'b1;
        sample = W'(16*9);
        repeat (20) begin
            check("bp_ready_low", ready, 0);
            check("bp_window_hold", window, snap);
            @(negedge clk);
        end
        core_ready = 1'b1;
        send(W'(16*9), 1'b0);
        check("bp_release_wait", last_wait, 2);
        check("bp_offers", offers, 5);
        for (int c = 1; c < CH; c++) send(W'(16*9 + c), 1'b0);
        idle(1);

        // Randomised traffic with random gaps and random core readiness
        for (int i = 0; i < 240; i++) begin
            send(W'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        core_ready = 1'b1;
        idle(3);
        check("random_drain", sb.size(), 0);

        // Flush on the 5th beat of the third frame; frame count keeps 2
        do_reset();
        send_frame(0);
        send_frame(1);
        for (int c = 0; c < 4; c++) send(W'(16*2 + c), 1'b0);
        valid  = 1'b1;
        sample = W'(16*2 + 4);
        flush  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        model_clear();
        check("flush_fill", fill, 0);
        check("flush_window", window, 0);
        check("flush_frame_count", fcount, 2);
        check("flush_ready", ready, 1);
        base = offers;
        for (int f = 0; f < DEPTH; f++) send_frame(20 + f);
        idle(1);
        check("flush_refill_offers", offers - base, 1);

        // Reset while an offer is pending
        core_ready = 1'b0;
        send_frame(30);
        idle(2);
        check("pend_before_reset", win_valid, 1);
        do_reset();
        check("rst2_ready", ready, 1);
        check("rst2_valid", win_valid, 0);
        check("rst2_window", window, 0);
        check("rst2_fill", fill, 0);
        check("rst2_frame_count", fcount, 0);
        core_ready = 1'b1;
        base = offers;
        for (int f = 0; f < DEPTH; f++) send_frame(40 + f);
        idle(2);
        check("rst_refill_offers", offers - base, 1);
        check("final_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glove_window_buffer.md
# glove_window_buffer

Parametrised sliding-window frame buffer between the glove sensor front end and `Core`. It accepts samples serially, one channel per beat, and assembles them into frames. It keeps the most recent DEPTH frames of CH channels and presents them flattened on `o_window` for `Core.i_data`. A window is offered to the core through a valid/ready handshake every HOP frames, with warm-up, back-pressure and flush. This moves the frame shifting that the bench currently does by hand into RTL.

## Interface
- CH, 8, channels per frame
- DEPTH, 5, frames per window
- W, 16, sample width (signed Q7.8)
- HOP, 1, committed frames between window offers after warm-up (≥1)
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, reset is synchronous and active-low
- i_valid  in  1  sample valid
- o_ready  out  1  sample accepted when i_valid & o_ready
- i_sample  in  W  signed sample; channel order 0..CH-1 within a frame
- i_flush  in  1  synchronous clear of window state
- o_window  out  DEPTH*CH*W  flattened window; element k = frame k/CH (0 oldest), channel k%CH, at bits [k*W +: W]
- o_window_valid  out  1  window offered to core
- i_core_ready  in  1  core takes window (integration drives `Core.i_next` = o_window_valid & i_core_ready)
- o_fill  out  $clog2(DEPTH+1)  committed frames in window, saturates at DEPTH
- o_frame_count  out  16  total committed frames, wraps at 2^16

## Operation
- Staging: a CH×W register with channel index ch_idx. On acceptance, write i_sample to stage[ch_idx], then ch_idx++.
- Commit: when the accepted beat has ch_idx==CH-1, ch_idx→0 and the window shifts by one frame. Frame 0 is dropped, frames 1..DEPTH-1 move down one slot, and slot DEPTH-1 receives stage[0..CH-2] plus the current i_sample.
  - On commit, fill increments (saturating at DEPTH) and o_frame_count increments (wrapping).
  - o_window never shows a partially written frame.
- FSM states:
  - S_FILL (fill<DEPTH): commits advance fill. The commit that makes fill==DEPTH moves to S_PEND and clears hop_cnt.
  - S_RUN: each commit increments hop_cnt. The commit that makes hop_cnt==HOP moves to S_PEND and clears hop_cnt.
  - S_PEND: o_window_valid=1 and o_ready=0. o_window is held stable. The cycle with i_core_ready=1 completes the handshake and returns to S_RUN.
- o_ready = 1 in S_FILL and S_RUN, 0 in S_PEND. Samples are never dropped or overwritten.
- i_flush, any state: ch_idx, stage, fill, hop_cnt and window are cleared to 0, state→S_FILL. o_frame_count is kept.
  - Flush wins over a same-cycle sample acceptance; that sample is discarded.
  - Flush wins over a same-cycle handshake; that handshake is not completed.
- Reset (i_rst_n=0 at a clock edge) clears all state including o_frame_count, state→S_FILL. Reset mid-frame or mid-pending abandons the frame or offer.
- No arithmetic on samples; data passes bit-exact.

## Timing
- Reset values: o_ready=1 (state S_FILL), o_window=0, o_window_valid=0, o_fill=0, o_frame_count=0.
- All outputs are registered or decoded from registered state. o_ready and o_window_valid have no combinational path from i_valid, i_sample or i_core_ready.
- Commit latency: the last channel accepted at edge N updates o_window, o_fill and o_frame_count after edge N. If an offer is due, o_window_valid=1 in the cycle after edge N.
- Warm-up: the first offer comes after DEPTH*CH accepted beats. At full rate and with i_core_ready held high, the offer is valid for one cycle. At HOP=1 and full rate, throughput is 1 window per CH+1 cycles, because the S_PEND cycle stalls input.
- i_core_ready asserted while not in S_PEND is ignored.
- i_valid while o_ready=0 is not accepted; the source must hold its sample.

## Test plan
- Warm-up: reset, then stream 40 samples of value 16*f+c (frame f, channel c) with i_core_ready=1.
  - Before beat 40: o_window_valid=0 and o_fill counts 0→4.
  - After beat 40: one cycle of o_window_valid, o_fill=5, o_window element k = 16*(k/8)+(k%8).
- Sliding at HOP=1: stream 3 more frames. Exactly 3 offers; the last offer's frame 0 holds 16*3+c and frame 4 holds 16*7+c. o_frame_count=8.
- Back-pressure: i_core_ready=0 for 20 cycles while pending.
  - o_ready=0 and o_window is unchanged; held i_valid beats are not consumed.
  - After i_core_ready=1, exactly one handshake occurs and the stalled beat is accepted on the next cycle.
- HOP=3, DEPTH=4, CH=2: stream 12 frames → offers after frames 4, 7 and 10 only.
- Flush: assert i_flush with i_valid on the 5th beat of frame 3 → o_fill=0, o_window=0, state S_FILL. A fresh 40 beats are needed before the next offer; o_frame_count retains 2.
- Reset during S_PEND → all outputs return to reset values next cycle; no o_window_valid until 40 new beats are accepted.
